// File: rtl/clock_gen.sv
// Multi-channel programmable clock divider with glitch-free divisor updates.
// Define CLKGEN_PENDING_STATUS_EN to expose the per-channel pending flags on cfg_pending.
module clock_gen #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 27,
    parameter int DIV_RST = 1,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              masterclock,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync_clr,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
`ifdef CLKGEN_PENDING_STATUS_EN
    output logic [NUM_CH-1:0] cfg_pending,
`endif
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_RST);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [CNT_W-1:0]  r_act  [NUM_CH];
    logic [CNT_W-1:0]  r_pend [NUM_CH];
    logic [CNT_W-1:0]  r_cnt  [NUM_CH];
    logic [NUM_CH-1:0] r_pflag;
    logic [NUM_CH-1:0] r_clk;
    logic [NUM_CH-1:0] r_tick;

    logic [CNT_W-1:0]  w_act_n  [NUM_CH];
    logic [CNT_W-1:0]  w_pend_n [NUM_CH];
    logic [CNT_W-1:0]  w_cnt_n  [NUM_CH];
    logic [NUM_CH-1:0] w_pflag_n;
    logic [NUM_CH-1:0] w_clk_n;
    logic [NUM_CH-1:0] w_tick_n;
    logic [NUM_CH-1:0] w_sel;
    logic [NUM_CH-1:0] w_run;
    logic [NUM_CH-1:0] w_tc;
    logic [NUM_CH-1:0] w_apply;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_sel[i]     = cfg_wr && (cfg_ch == CH_W'(i));
            w_run[i]     = ch_en[i] && (r_act[i] != '0);
            w_tc[i]      = w_run[i] && (r_cnt[i] == r_act[i] - ONE);
            w_apply[i]   = !w_run[i] || w_tc[i];
            w_act_n[i]   = r_act[i];
            w_pend_n[i]  = r_pend[i];
            w_pflag_n[i] = r_pflag[i];
            w_cnt_n[i]   = '0;
            w_clk_n[i]   = 1'b0;
            w_tick_n[i]  = 1'b0;
            if (sync_clr) begin
                // A write in the same cycle is applied together with the restart
                if (w_sel[i]) begin
                    w_act_n[i]  = cfg_div;
                    w_pend_n[i] = cfg_div;
                end else if (r_pflag[i]) begin
                    w_act_n[i] = r_pend[i];
                end
                w_pflag_n[i] = 1'b0;
            end else begin
                if (w_tc[i]) begin
                    w_clk_n[i]  = ~r_clk[i];
                    w_tick_n[i] = ~r_clk[i];
                end else if (w_run[i]) begin
                    w_cnt_n[i] = r_cnt[i] + ONE;
                    w_clk_n[i] = r_clk[i];
                end
                if (w_apply[i] && r_pflag[i]) begin
                    w_act_n[i]   = r_pend[i];
                    w_pflag_n[i] = 1'b0;
                end
                // Written after the apply so a write at terminal count waits a full half-period
                if (w_sel[i]) begin
                    w_pend_n[i]  = cfg_div;
                    w_pflag_n[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge masterclock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_act[i]  <= DIV_INIT;
                r_pend[i] <= DIV_INIT;
                r_cnt[i]  <= '0;
            end
            r_pflag <= '0;
            r_clk   <= '0;
            r_tick  <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_act[i]  <= w_act_n[i];
                r_pend[i] <= w_pend_n[i];
                r_cnt[i]  <= w_cnt_n[i];
            end
            r_pflag <= w_pflag_n;
            r_clk   <= w_clk_n;
            r_tick  <= w_tick_n;
        end
    end

    assign clk_out = r_clk;
    assign tick    = r_tick;
`ifdef CLKGEN_PENDING_STATUS_EN
    assign cfg_pending = r_pflag;
`endif

endmodule
